// File: rtl/qmax_updater.sv
// qmax_updater: write-side controller for the per-state qmax table.
// Accepts (state, q) updates, performs a signed read-compare-write on the
// table entry, reports the resulting qmax, and zero-fills the whole table
// after reset or on an i_clear request.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_valid / o_ready            update handshake (accepted when both high)
//   i_state, i_q                 update state index and signed Q-value
//   i_clear / o_busy             start zero-fill sweep / sweep or drain active
//   o_tbl_addr_r, o_tbl_read_en  table read port (data returns next cycle)
//   i_tbl_data                   table read data
//   o_tbl_addr_w, o_tbl_write_en, o_tbl_data   table write port
//   o_qmax_valid, o_qmax, o_qmax_state         per-update result pulse
module qmax_updater #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_state,
   input  logic [DATA_WIDTH-1:0] i_q,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
   output logic                  o_tbl_read_en,
   input  logic [DATA_WIDTH-1:0] i_tbl_data,
   output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
   output logic                  o_tbl_write_en,
   output logic [DATA_WIDTH-1:0] o_tbl_data,
   output logic                  o_qmax_valid,
   output logic [DATA_WIDTH-1:0] o_qmax,
   output logic [ADDR_WIDTH-1:0] o_qmax_state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

   logic                    s1_valid_q, s1_valid_d;
   logic [ADDR_WIDTH-1:0]   s1_state_q, s1_state_d;
   logic [DATA_WIDTH-1:0]   s1_qval_q,  s1_qval_d;

   logic                    s2_valid_q, s2_valid_d;
   logic [ADDR_WIDTH-1:0]   s2_state_q, s2_state_d;
   logic [DATA_WIDTH-1:0]   s2_new_q,   s2_new_d;
   logic                    s2_wr_q,    s2_wr_d;

   logic                    clear_we;
   logic                    clear_act;
   logic                    s2_we;
   logic                    accept;
   logic                    fwd_hit;
   logic                    q_higher;
   logic [DATA_WIDTH-1:0]   cur;

   // State, sweep counter and pipeline registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_CLEAR;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_state_q <= '0;
         s1_qval_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_state_q <= '0;
         s2_new_q   <= '0;
         s2_wr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_state_q <= s1_state_d;
         s1_qval_q  <= s1_qval_d;
         s2_valid_q <= s2_valid_d;
         s2_state_q <= s2_state_d;
         s2_new_q   <= s2_new_d;
         s2_wr_q    <= s2_wr_d;
      end
   end

   // Sweep / run / drain control
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      o_ready  = 1'b0;
      o_busy   = 1'b1;
      clear_we = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clear_we = 1'b1;
            cnt_d    = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            o_busy  = 1'b0;
            o_ready = ~i_clear;
            if (i_clear) begin
               cnt_d = '0;
               // An update still in S1 reaches the write port next cycle;
               // hold off the sweep until it has gone through.
               state_d = s1_valid_q ? ST_DRAIN : ST_CLEAR;
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_q) state_d = ST_CLEAR;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Read-compare-write pipeline
   always_comb begin
      accept        = i_valid & o_ready;
      o_tbl_read_en = accept;
      o_tbl_addr_r  = accept ? i_state : '0;

      s1_valid_d = accept;
      s1_state_d = accept ? i_state : '0;
      s1_qval_d  = accept ? i_q : '0;

      // S2's result is the entry's current value whether or not it wrote;
      // the array read issued alongside it still returns the old value.
      fwd_hit  = s2_valid_q && (s2_state_q == s1_state_q);
      cur      = fwd_hit ? s2_new_q : i_tbl_data;
      q_higher = $signed(s1_qval_q) > $signed(cur);

      s2_valid_d = s1_valid_q;
      s2_state_d = s1_state_q;
      s2_new_d   = q_higher ? s1_qval_q : cur;
      s2_wr_d    = s1_valid_q & q_higher;
   end

   // Table write port: sweep writes and S2 writes never overlap
   always_comb begin
      clear_act      = clear_we & ~i_rst;
      s2_we          = s2_valid_q & s2_wr_q;
      o_tbl_write_en = clear_act | s2_we;
      o_tbl_addr_w   = '0;
      o_tbl_data     = '0;
      if (clear_act) begin
         o_tbl_addr_w = cnt_q;
      end else if (s2_we) begin
         o_tbl_addr_w = s2_state_q;
         o_tbl_data   = s2_new_q;
      end
   end

   assign o_qmax_valid = s2_valid_q;
   assign o_qmax       = s2_new_q;
   assign o_qmax_state = s2_state_q;

endmodule
